sd_dumper: RTL

- Write-direction counterpart of the microSD boot loader: copies a RAM region back to consecutive microSD sectors.
- Fetches 32-bit words from RAM through a request/valid handshake and packs them little-endian into a 512-byte sector buffer.
- Feeds each full buffer to the byte-serial SD sector writer through a start/busy/done plus byte-pull interface.
- Sits between the RAM controller and the SD writer PHY in the same clock domain.

---
 rtl/sd_dumper.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_dumper.sv
// sd_dumper: copies a RAM region to consecutive microSD sectors.
// Fetches 32-bit words from RAM, packs them little-endian into a one-sector
// buffer, then streams the buffer to the byte-serial SD sector writer.
// Ports:
//   clk27mhz, reset            clock, async active-high reset
//   start, base_sector, nbytes dump request and its parameters
//   RADDR, RREQ, RDATA, RVALID RAM word read handshake
//   wstart, wsector, wbusy,
//   wdone, inreq, inbyte       SD sector writer handshake and byte pull
//   BUSY, DONE, sectors_written status
module sd_dumper #(
    parameter int unsigned SECTOR_SIZE = 512,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        clk27mhz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_sector,
    input  logic [31:0] nbytes,
    output logic [31:0] RADDR,
    output logic        RREQ,
    input  logic [31:0] RDATA,
    input  logic        RVALID,
    output logic        wstart,
    output logic [31:0] wsector,
    input  logic        wbusy,
    input  logic        wdone,
    input  logic        inreq,
    output logic [7:0]  inbyte,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] sectors_written
);

    localparam int unsigned WP_W   = $clog2(SECTOR_SIZE);
    localparam int unsigned RP_W   = WP_W + 1;
    localparam int unsigned NWORDS = SECTOR_SIZE / 4;
    localparam int unsigned WI_W   = WP_W - 2;

    typedef enum logic [2:0] {
        IDLE, FILL_REQ, FILL_WAIT, WR_START, WR_WAIT, NEXT, DONE_ST
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       nbytes_q, nbytes_d;
    logic [31:0]       sec_q, sec_d;
    logic [31:0]       waddr_q, waddr_d;
    logic [WP_W-1:0]   wp_q, wp_d;
    logic [RP_W-1:0]   rp_q, rp_d;
    logic [7:0]        inbyte_q, inbyte_d;
    logic              rreq_q, rreq_d;
    logic [31:0]       raddr_q, raddr_d;
    logic              wstart_q, wstart_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       sw_q, sw_d;
    logic              last_q, last_d;

    // Sector buffer, word organised; contents need no reset.
    logic [31:0]       mem_q [NWORDS];
    logic              we_c;
    logic [WI_W-1:0]   widx_c;
    logic [31:0]       wdata_c;

    logic [31:0]       avail_c;
    logic [32:0]       waddr_nx_c;
    logic              end_c;
    logic [WP_W-1:0]   rd_idx_c;

    // Next-state and datapath logic.
    always_comb begin
        state_d    = state_q;
        nbytes_d   = nbytes_q;
        sec_d      = sec_q;
        waddr_d    = waddr_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        inbyte_d   = inbyte_q;
        rreq_d     = rreq_q;
        raddr_d    = raddr_q;
        wstart_d   = wstart_q;
        done_d     = done_q;
        sw_d       = sw_q;
        last_d     = last_q;
        we_c       = 1'b0;
        widx_c     = wp_q[WP_W-1:2];
        wdata_c    = RDATA;
        // Real bytes left from the current word onward; waddr < nbytes while fetching.
        avail_c    = nbytes_q - waddr_q;
        waddr_nx_c = {1'b0, waddr_q} + 33'd4;
        end_c      = (waddr_nx_c >= {1'b0, nbytes_q});
        rd_idx_c   = '0;

        case (state_q)
            IDLE, DONE_ST: begin
                if (state_q == DONE_ST) done_d = 1'b1;
                if (start) begin
                    nbytes_d = nbytes;
                    sec_d    = base_sector;
                    waddr_d  = '0;
                    wp_d     = '0;
                    sw_d     = '0;
                    done_d   = 1'b0;
                    last_d   = 1'b0;
                    state_d  = (nbytes == 32'd0) ? DONE_ST : FILL_REQ;
                end
            end
            FILL_REQ: begin
                rreq_d  = 1'b1;
                raddr_d = waddr_q;
                state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (RVALID) begin
                    we_c = 1'b1;
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (i >= avail_c) wdata_c[8*i +: 8] = PAD_BYTE;
                    end
                    waddr_d = waddr_nx_c[31:0];
                    wp_d    = wp_q + WP_W'(4);
                    rreq_d  = 1'b0;
                    last_d  = end_c;
                    state_d = ((wp_d == '0) || end_c) ? WR_START : FILL_REQ;
                end
            end
            WR_START: begin
                rp_d = '0;
                if (wp_q != '0) begin
                    // Pad the tail of a partial last sector before handing it over.
                    we_c    = 1'b1;
                    wdata_c = {4{PAD_BYTE}};
                    wp_d    = wp_q + WP_W'(4);
                end else begin
                    inbyte_d = mem_q[0][7:0];
                    if (wstart_q && wbusy) begin
                        wstart_d = 1'b0;
                        state_d  = WR_WAIT;
                    end else begin
                        wstart_d = 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                // wdone has priority over a coincident byte pull.
                if (wdone) begin
                    sw_d    = sw_q + 32'd1;
                    state_d = NEXT;
                end else if (inreq && (rp_q < RP_W'(SECTOR_SIZE))) begin
                    rp_d     = rp_q + RP_W'(1);
                    rd_idx_c = rp_d[WP_W-1:0];
                    inbyte_d = (rp_d < RP_W'(SECTOR_SIZE))
                             ? mem_q[rd_idx_c[WP_W-1:2]][{rd_idx_c[1:0], 3'b000} +: 8]
                             : PAD_BYTE;
                end
            end
            NEXT: begin
                sec_d   = sec_q + 32'd1;
                wp_d    = '0;
                state_d = last_q ? DONE_ST : FILL_REQ;
            end
            default: state_d = IDLE;
        endcase

        busy_d = !((state_d == IDLE) || (state_d == DONE_ST));
    end

    // State and output registers.
    always_ff @(posedge clk27mhz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            nbytes_q <= '0;
            sec_q    <= '0;
            waddr_q  <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            inbyte_q <= '0;
            rreq_q   <= 1'b0;
            raddr_q  <= '0;
            wstart_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sw_q     <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nbytes_q <= nbytes_d;
            sec_q    <= sec_d;
            waddr_q  <= waddr_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            inbyte_q <= inbyte_d;
            rreq_q   <= rreq_d;
            raddr_q  <= raddr_d;
            wstart_q <= wstart_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sw_q     <= sw_d;
            last_q   <= last_d;
        end
    end

    // Sector buffer write port.
    always_ff @(posedge clk27mhz) begin
        if (we_c) mem_q[widx_c] <= wdata_c;
    end

    assign RADDR           = raddr_q;
    assign RREQ            = rreq_q;
    assign wstart          = wstart_q;
    assign wsector         = sec_q;
    assign inbyte          = inbyte_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign sectors_written = sw_q;

endmodule
